alu_exception_unit: RTL and testbench
=====================================

Name: alu_exception_unit

Overview:
- Consumer end of the ALU result/status interface: samples the 8-bit ALU status on each valid execute cycle and keeps the architectural condition flags.
- Converts overflow, misaligned-address and divide-by-zero indications into a precise exception request to the control unit, with EPC/Cause capture.
- Handshakes with the control unit through ack/eret; masks nested exceptions while a handler runs.
- Sits between the execute-stage ALU and the pipeline/PC control logic.

Parameters:
- DATA_W, 32, width of PC/EPC.
- CAUSE_W, 5, width of the exception cause code.
- CNT_W, 16, width of per-cause event counters (optional feature only).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- status_valid  in  1  execute stage holds a valid ALU operation this cycle.
- alu_status  in  8  [7] zero, [6] overflow, [5] carry, [4] negative, [3] misaligned, [2] divide-by-zero, [1:0] reserved/ignored.
- pc_ex  in  DATA_W  PC of the instruction in execute.
- exc_ack  in  1  control unit accepts the exception (vectoring).
- eret  in  1  handler return; re-enables exceptions.
- flags  out  4  registered {zero, carry, negative, overflow} of the last valid ALU op.
- exc_req  out  1  exception request, level, held until acknowledged.
- exc_flush  out  1  one-cycle pulse to squash the faulting instruction's writeback.
- exc_cause  out  CAUSE_W  cause code of the pending/active exception.
- epc  out  DATA_W  PC of the faulting instruction.
- exc_overrun  out  1  one-cycle pulse: exception condition arrived while masked.
- cnt_sel  in  2  counter select (optional feature).
- cnt_val  out  CNT_W  selected counter value (optional feature; 0 when compiled out).

Behaviour:
- Reset: all outputs 0; state IDLE; flags 4'b0000; epc 0; exc_cause 0.
- Flags: on every clk with status_valid=1, flags <= {s[7],s[5],s[4],s[6]}, in any state. Without status_valid, flags hold.
- Exception detect: exc_hit = status_valid & (s[6] | s[3] | s[2]).
- Priority: overflow (cause 12) > misaligned (cause 4) > divide-by-zero (cause 13).
- FSM states IDLE, REQ, HANDLER.
  - IDLE: on exc_hit -> REQ next edge. Same edge: epc <= pc_ex, exc_cause <= priority code, exc_req <= 1, exc_flush <= 1 for exactly one cycle. Latency detect->exc_req is 1 cycle.
  - REQ: exc_req held high, epc/cause frozen. exc_ack sampled high -> HANDLER; exc_req low next cycle.
  - HANDLER: exc_req low; epc/cause hold for handler reads. eret sampled high -> IDLE.
- exc_ack outside REQ and eret outside HANDLER are ignored.
- exc_hit in REQ or HANDLER: no capture, no state change; exc_overrun pulses 1 cycle.
- Same edge eret and exc_hit in HANDLER: the exception counts as masked (overrun pulse); returns to IDLE; the new exception is lost.
- Same edge exc_ack and exc_hit in REQ: goes to HANDLER; overrun pulse.
- Multiple simultaneous status bits: only the highest-priority cause is recorded; lower ones are dropped, no overrun.
- exc_cause and epc retain their last values in IDLE until the next capture.
- rst asserted in any state: next edge returns to IDLE with all outputs cleared. This includes mid-REQ (exc_req drops without ack).

Optional Feature:
- Macro ALU_EXC_COUNT_EN.
- Defined: three CNT_W-bit saturating counters: overflow, misaligned, divide-by-zero.
  - Each increments on every status_valid cycle whose corresponding bit is set, independent of priority and masking. Saturates at all-ones.
  - cnt_sel 0/1/2 selects overflow/misaligned/div0; cnt_sel 3 selects the overrun count.
  - cnt_val is combinational from the registers. Counters are cleared by rst.
- Undefined: no counter registers; cnt_val tied to 0; cnt_sel unused.

Test Plan:
- Reset, then status_valid=1, alu_status=8'h90 -> next cycle flags=4'b1010 (zero, negative), exc_req=0.
- IDLE, status_valid=1, alu_status=8'h40, pc_ex=32'h0040_0010 -> next cycle exc_req=1, exc_flush=1 for one cycle, exc_cause=12, epc=32'h0040_0010. Hold exc_ack=0 for 5 cycles: exc_req stays 1. Assert exc_ack: exc_req=0 next cycle.
- alu_status=8'h4C (overflow+misaligned+div0) -> exc_cause=12 only. Later, IDLE with alu_status=8'h0C -> exc_cause=4.
- In HANDLER, status_valid=1, alu_status=8'h04, pc_ex=32'h100 -> exc_overrun pulse; epc unchanged. eret -> IDLE. Repeating div0 -> exc_cause=13, epc=32'h100.
- In REQ, assert rst one cycle -> exc_req=0, flags=0, epc=0. Following exc_ack is ignored; state stays IDLE.
- With ALU_EXC_COUNT_EN: 3 overflow ops plus 1 masked div0 -> cnt_sel=0 gives 3, cnt_sel=2 gives 1, cnt_sel=3 gives the overrun count. Force 2^CNT_W+2 overflow events -> counter stays 16'hFFFF.

Source files
------------

// File: rtl/alu_exception_unit.sv
// ALU status consumer: keeps condition flags, raises precise exceptions with EPC/cause capture.
// Optional per-cause event counters are compiled in with ALU_EXC_COUNT_EN.
module alu_exception_unit #(
    parameter int DATA_W  = 32,
    parameter int CAUSE_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               status_valid,
    input  logic [7:0]         alu_status,
    input  logic [DATA_W-1:0]  pc_ex,
    input  logic               exc_ack,
    input  logic               eret,
    output logic [3:0]         flags,
    output logic               exc_req,
    output logic               exc_flush,
    output logic [CAUSE_W-1:0] exc_cause,
    output logic [DATA_W-1:0]  epc,
    output logic               exc_overrun,
    input  logic [1:0]         cnt_sel,
    output logic [CNT_W-1:0]   cnt_val
);
    typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;

    state_t             state_q, state_d;
    logic [3:0]         flags_q, flags_d;
    logic               exc_req_q, exc_req_d;
    logic               exc_flush_q, exc_flush_d;
    logic [CAUSE_W-1:0] exc_cause_q, exc_cause_d;
    logic [DATA_W-1:0]  epc_q, epc_d;
    logic               exc_overrun_q, exc_overrun_d;

    logic               exc_hit;
    logic [CAUSE_W-1:0] hit_cause;

    assign exc_hit = status_valid & (alu_status[6] | alu_status[3] | alu_status[2]);

    always_comb begin
        hit_cause = CAUSE_W'(13);
        if (alu_status[6])      hit_cause = CAUSE_W'(12);
        else if (alu_status[3]) hit_cause = CAUSE_W'(4);
    end

    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        exc_cause_d   = exc_cause_q;
        epc_d         = epc_q;
        exc_flush_d   = 1'b0;
        exc_overrun_d = 1'b0;

        if (status_valid)
            flags_d = {alu_status[7], alu_status[5], alu_status[4], alu_status[6]};

        case (state_q)
            IDLE: begin
                if (exc_hit) begin
                    state_d     = REQ;
                    epc_d       = pc_ex;
                    exc_cause_d = hit_cause;
                    exc_flush_d = 1'b1;
                end
            end
            REQ: begin
                // A new hit while waiting for ack is masked, even on the ack edge.
                exc_overrun_d = exc_hit;
                if (exc_ack) state_d = HANDLER;
            end
            HANDLER: begin
                exc_overrun_d = exc_hit;
                if (eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        exc_req_d = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            flags_q       <= '0;
            exc_req_q     <= 1'b0;
            exc_flush_q   <= 1'b0;
            exc_cause_q   <= '0;
            epc_q         <= '0;
            exc_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            exc_req_q     <= exc_req_d;
            exc_flush_q   <= exc_flush_d;
            exc_cause_q   <= exc_cause_d;
            epc_q         <= epc_d;
            exc_overrun_q <= exc_overrun_d;
        end
    end

    assign flags       = flags_q;
    assign exc_req     = exc_req_q;
    assign exc_flush   = exc_flush_q;
    assign exc_cause   = exc_cause_q;
    assign epc         = epc_q;
    assign exc_overrun = exc_overrun_q;

`ifdef ALU_EXC_COUNT_EN
    logic [CNT_W-1:0] cnt_ov_q, cnt_ov_d;
    logic [CNT_W-1:0] cnt_mis_q, cnt_mis_d;
    logic [CNT_W-1:0] cnt_dz_q, cnt_dz_d;
    logic [CNT_W-1:0] cnt_orun_q, cnt_orun_d;
    logic [1:0]       unused_status;

    assign unused_status = alu_status[1:0];

    // Counters see raw status bits, regardless of priority or masking.
    always_comb begin
        cnt_ov_d   = cnt_ov_q;
        cnt_mis_d  = cnt_mis_q;
        cnt_dz_d   = cnt_dz_q;
        cnt_orun_d = cnt_orun_q;
        if (status_valid && alu_status[6] && cnt_ov_q  != '1) cnt_ov_d  = cnt_ov_q + 1'b1;
        if (status_valid && alu_status[3] && cnt_mis_q != '1) cnt_mis_d = cnt_mis_q + 1'b1;
        if (status_valid && alu_status[2] && cnt_dz_q  != '1) cnt_dz_d  = cnt_dz_q + 1'b1;
        if (exc_overrun_d && cnt_orun_q != '1)                cnt_orun_d = cnt_orun_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ov_q   <= '0;
            cnt_mis_q  <= '0;
            cnt_dz_q   <= '0;
            cnt_orun_q <= '0;
        end else begin
            cnt_ov_q   <= cnt_ov_d;
            cnt_mis_q  <= cnt_mis_d;
            cnt_dz_q   <= cnt_dz_d;
            cnt_orun_q <= cnt_orun_d;
        end
    end

    always_comb begin
        case (cnt_sel)
            2'd0:    cnt_val = cnt_ov_q;
            2'd1:    cnt_val = cnt_mis_q;
            2'd2:    cnt_val = cnt_dz_q;
            default: cnt_val = cnt_orun_q;
        endcase
    end
`else
    logic [3:0] unused_inputs;
    assign unused_inputs = {cnt_sel, alu_status[1:0]};
    assign cnt_val       = '0;
`endif

endmodule

// File: tb/tb_alu_exception_unit.sv
// Randomized + directed bench for alu_exception_unit; a cycle-level reference model
// pushes expected outputs into a queue that a separate monitor pops and compares.
module tb_alu_exception_unit;
    localparam int DATA_W  = 32;
    localparam int CAUSE_W = 5;
    localparam int CNT_W   = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               status_valid = 1'b0;
    logic [7:0]         alu_status = 8'h00;
    logic [DATA_W-1:0]  pc_ex = '0;
    logic               exc_ack = 1'b0;
    logic               eret = 1'b0;
    logic [1:0]         cnt_sel = 2'd0;
    logic [3:0]         flags;
    logic               exc_req, exc_flush, exc_overrun;
    logic [CAUSE_W-1:0] exc_cause;
    logic [DATA_W-1:0]  epc;
    logic [CNT_W-1:0]   cnt_val;

    alu_exception_unit #(.DATA_W(DATA_W), .CAUSE_W(CAUSE_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .status_valid(status_valid), .alu_status(alu_status),
        .pc_ex(pc_ex), .exc_ack(exc_ack), .eret(eret), .flags(flags),
        .exc_req(exc_req), .exc_flush(exc_flush), .exc_cause(exc_cause), .epc(epc),
        .exc_overrun(exc_overrun), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flags;
        logic        req;
        logic        flush;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic        ovr;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = exceptions enabled, 1 = awaiting ack, 2 = in handler.
    int          m_mode = 0;
    logic [3:0]  m_flags = '0;
    logic [4:0]  m_cause = '0;
    logic [31:0] m_epc = '0;
    int          m_cnt[4] = '{0, 0, 0, 0};

    task automatic step(input logic r, input logic sv, input logic [7:0] st,
                        input logic [31:0] pc, input logic ack, input logic er,
                        input logic [1:0] sel);
        exp_t e;
        bit hit, ovr, flush;
        @(negedge clk);
        rst = r; status_valid = sv; alu_status = st; pc_ex = pc;
        exc_ack = ack; eret = er; cnt_sel = sel;
        flush = 0; ovr = 0;
        if (r) begin
            m_mode = 0; m_flags = '0; m_cause = '0; m_epc = '0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            hit = sv && (st[6] || st[3] || st[2]);
            if (sv) begin
                m_flags = {st[7], st[5], st[4], st[6]};
                if (st[6] && m_cnt[0] < CMAX) m_cnt[0]++;
                if (st[3] && m_cnt[1] < CMAX) m_cnt[1]++;
                if (st[2] && m_cnt[2] < CMAX) m_cnt[2]++;
            end
            if (m_mode == 0) begin
                if (hit) begin
                    m_mode = 1; m_epc = pc; flush = 1;
                    m_cause = st[6] ? 5'd12 : (st[3] ? 5'd4 : 5'd13);
                end
            end else begin
                ovr = hit;
                if (m_mode == 1 && ack) m_mode = 2;
                else if (m_mode == 2 && er) m_mode = 0;
            end
            if (ovr && m_cnt[3] < CMAX) m_cnt[3]++;
        end
        e.flags = m_flags; e.req = (m_mode == 1); e.flush = flush;
        e.cause = m_cause; e.epc = m_epc; e.ovr = ovr;
`ifdef ALU_EXC_COUNT_EN
        e.cnt = 16'(m_cnt[sel]);
`else
        e.cnt = 16'h0;
`endif
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one registered response per cycle, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("flags", 32'(flags), 32'(e.flags));
                chk("exc_req", 32'(exc_req), 32'(e.req));
                chk("exc_flush", 32'(exc_flush), 32'(e.flush));
                chk("exc_cause", 32'(exc_cause), 32'(e.cause));
                chk("epc", epc, e.epc);
                chk("exc_overrun", 32'(exc_overrun), 32'(e.ovr));
                chk("cnt_val", 32'(cnt_val), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [7:0] st;
        int budget;
        // reset and flags
        step(1, 0, 8'h00, 0, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        step(0, 1, 8'h90, 0, 0, 0, 0);
        // overflow exception, ack held off for 5 cycles
        step(0, 1, 8'h40, 32'h0040_0010, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1, 0);
        // priority
        step(0, 1, 8'h4C, 32'h200, 0, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1, 0);
        step(0, 1, 8'h0C, 32'h300, 0, 0, 1);
        step(0, 0, 8'h00, 0, 1, 0, 0);
        // masked div0 in handler, then eret and retry
        step(0, 1, 8'h04, 32'h100, 0, 0, 2);
        step(0, 0, 8'h00, 0, 0, 1, 3);
        step(0, 1, 8'h04, 32'h100, 0, 0, 0);
        // same-edge ack+hit, then same-edge eret+hit
        step(0, 1, 8'h40, 32'h500, 1, 0, 3);
        step(0, 1, 8'h08, 32'h600, 0, 1, 3);
        // reset in REQ; following ack ignored
        step(0, 1, 8'h08, 32'h700, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1, 0);
`ifdef ALU_EXC_COUNT_EN
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 8'h40, 32'h10 + i, 0, 0, 0);
            step(0, 0, 8'h00, 0, 1, 0, 0);
            step(0, 0, 8'h00, 0, 0, 1, 0);
        end
        step(0, 1, 8'h40, 32'h20, 0, 0, 0);
        step(0, 1, 8'h04, 32'h24, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 2);
        step(0, 0, 8'h00, 0, 0, 0, 3);
        for (int i = 0; i < (1 << CNT_W) + 2; i++) step(0, 1, 8'h40, 32'h30, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0, 3);
`endif
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            st = 8'($urandom);
            if ($urandom_range(0, 1) == 0) st = st & 8'hB3;
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, st, $urandom,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 2'($urandom));
        end
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
